// File: rtl/sha256_round_ctrl_if.sv
// sha256_round_ctrl_if: host/datapath strobes and round-counter feedback of the SHA-256 round controller
interface sha256_round_ctrl_if;
  logic       i_start;
  logic       i_first;
  logic       i_abort;
  logic       i_wvalid;
  logic [5:0] j;
  logic       o_wready;
  logic       o_clr_j;
  logic       o_cnt_j_en;
  logic       o_init_h;
  logic       o_load_w;
  logic       o_sel_w;
  logic       o_round_en;
  logic       o_upd_h;
  logic       o_busy;
  logic       o_done;
  modport master (
    output i_start, i_first, i_abort, i_wvalid, j,
    input  o_wready, o_clr_j, o_cnt_j_en, o_init_h, o_load_w, o_sel_w, o_round_en, o_upd_h, o_busy, o_done
  );
  modport slave (
    input  i_start, i_first, i_abort, i_wvalid, j,
    output o_wready, o_clr_j, o_cnt_j_en, o_init_h, o_load_w, o_sel_w, o_round_en, o_upd_h, o_busy, o_done
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequences message load and compression rounds of one SHA-256 block via an external round counter
module sha256_round_ctrl #(
  parameter int WORDS  = 16,
  parameter int ROUNDS = 64
) (
  input logic              i_clk,
  input logic              i_rst,
  sha256_round_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
  localparam logic [5:0] W_LAST = 6'(WORDS - 1);
  localparam logic [5:0] R_LAST = 6'(ROUNDS - 1);
  localparam logic [5:0] W_NUM  = 6'(WORDS);
  state_t state_q, state_d;
  always_comb begin
    state_d        = state_q;
    bus.o_wready   = 1'b0;
    bus.o_clr_j    = 1'b0;
    bus.o_cnt_j_en = 1'b0;
    bus.o_init_h   = 1'b0;
    bus.o_load_w   = 1'b0;
    bus.o_sel_w    = 1'b0;
    bus.o_round_en = 1'b0;
    bus.o_upd_h    = 1'b0;
    bus.o_done     = 1'b0;
    bus.o_busy     = state_q != IDLE;
    case (state_q)
      IDLE: begin
        bus.o_clr_j  = 1'b1;
        bus.o_init_h = bus.i_start & bus.i_first;
        state_d      = bus.i_start ? LOAD : IDLE;
      end
      LOAD: begin
        // abort clears the counter and suppresses every other strobe, including the word handshake
        bus.o_clr_j    = bus.i_abort | (bus.i_wvalid & (bus.j == W_LAST));
        bus.o_wready   = ~bus.i_abort;
        bus.o_load_w   = ~bus.i_abort & bus.i_wvalid;
        bus.o_cnt_j_en = ~bus.i_abort & bus.i_wvalid & (bus.j != W_LAST);
        state_d        = bus.i_abort ? IDLE : (bus.i_wvalid && bus.j == W_LAST) ? ROUND : LOAD;
      end
      ROUND: begin
        bus.o_clr_j    = bus.i_abort | (bus.j == R_LAST);
        bus.o_round_en = ~bus.i_abort;
        bus.o_sel_w    = ~bus.i_abort & (bus.j >= W_NUM);
        bus.o_cnt_j_en = ~bus.i_abort & (bus.j != R_LAST);
        state_d        = bus.i_abort ? IDLE : (bus.j == R_LAST) ? FINAL : ROUND;
      end
      FINAL: begin
        bus.o_upd_h = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        bus.o_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) state_q <= i_rst ? IDLE : state_d;
endmodule
